// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Latency-aware RAW/WAW hazard tracker that sits beside the ID stage. Each
// architectural register owns a small down-counter holding the number of cycles
// until its pending write becomes forwardable to an EX-stage consumer. The ID
// instruction is checked against these counters and, when it cannot proceed,
// the front end is held and a bubble is pushed into ID/EX.
//
// Parameters
//   NUM_REGS  number of architectural registers (register 0 reads as zero)
//   AW        register address width, 2**AW >= NUM_REGS
//   LAT_W     width of each per-register latency counter
//   CNT_W     width of the saturating hazard-stall performance counter
//
// Ports
//   i_clk            clock, all state changes on the rising edge
//   i_rst_n          asynchronous active-low reset
//   i_id_valid       ID holds a valid instruction
//   i_rs1, i_rs2     ID source registers
//   i_use_rs1/2      the corresponding source is actually read
//   i_is_branch      ID instruction is a branch resolved in ID
//   i_is_jump        ID instruction is a JALR resolved in ID
//   i_rd             ID destination register
//   i_reg_write      ID instruction writes i_rd
//   i_lat            cycles after issue until the result is forwardable to EX
//   i_mem_stall      global pipeline freeze from the memory system
//   i_flush          redirect squashes the ID instruction this cycle
//   o_stall_if       hold the PC
//   o_stall_id       hold IF/ID
//   o_flush_id_ex    insert a bubble into ID/EX
//   o_flush_if_id    always 0 (redirect flushes are owned elsewhere)
//   o_pending        bit r set while register r has an outstanding write
//   o_stall_cycles   saturating count of hazard-induced stall cycles
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int AW       = 5,
    parameter int LAT_W    = 3,
    parameter int CNT_W    = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_id_valid,
    input  logic [AW-1:0]       i_rs1,
    input  logic [AW-1:0]       i_rs2,
    input  logic                i_use_rs1,
    input  logic                i_use_rs2,
    input  logic                i_is_branch,
    input  logic                i_is_jump,
    input  logic [AW-1:0]       i_rd,
    input  logic                i_reg_write,
    input  logic [LAT_W-1:0]    i_lat,
    input  logic                i_mem_stall,
    input  logic                i_flush,
    output logic                o_stall_if,
    output logic                o_stall_id,
    output logic                o_flush_id_ex,
    output logic                o_flush_if_id,
    output logic [NUM_REGS-1:0] o_pending,
    output logic [CNT_W-1:0]    o_stall_cycles
);

    // The counter view is padded to the full address space so that any
    // register address indexes a defined entry; x0 and unimplemented
    // addresses always read as "nothing pending".
    localparam int DEPTH = 1 << AW;

    localparam logic [LAT_W-1:0] LAT_ZERO = '0;
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

    logic [LAT_W-1:0] cnt_view [DEPTH];

    logic             id_resolves;
    logic [LAT_W-1:0] rs1_cnt;
    logic [LAT_W-1:0] rs2_cnt;
    logic [LAT_W-1:0] rd_cnt;
    logic             rs1_haz;
    logic             rs2_haz;
    logic             waw_haz;
    logic             haz;
    logic             issue;
    logic             rd_nonzero;

    logic [CNT_W-1:0] stall_cycles_reg;
    logic [CNT_W-1:0] stall_cycles_next;

    // -------------------------------------------------------------------------
    // Hazard decision (purely combinational, zero-cycle latency)
    // -------------------------------------------------------------------------
    assign rs1_cnt    = cnt_view[i_rs1];
    assign rs2_cnt    = cnt_view[i_rs2];
    assign rd_cnt     = cnt_view[i_rd];
    assign rd_nonzero = (i_rd != '0);

    // Branches and JALR compare their operands in ID, one stage earlier than
    // an EX consumer, so they need the value a full cycle sooner: any
    // remaining latency is a hazard. An EX consumer can take the value on the
    // forwarding path in the cycle the counter reaches 1.
    assign id_resolves = i_is_branch | i_is_jump;

    always_comb begin
        rs1_haz = 1'b0;
        if (i_use_rs1 && (i_rs1 != '0)) begin
            if (id_resolves) begin
                rs1_haz = (rs1_cnt != LAT_ZERO);
            end else begin
                rs1_haz = (rs1_cnt > LAT_ONE);
            end
        end
    end

    always_comb begin
        rs2_haz = 1'b0;
        if (i_use_rs2 && (i_rs2 != '0)) begin
            if (id_resolves) begin
                rs2_haz = (rs2_cnt != LAT_ZERO);
            end else begin
                rs2_haz = (rs2_cnt > LAT_ONE);
            end
        end
    end

    // A faster producer must not overtake a slower one still in flight to the
    // same register, otherwise the older result would land last.
    assign waw_haz = i_reg_write && rd_nonzero && (rd_cnt > i_lat);

    assign haz   = i_id_valid && !i_flush && (rs1_haz || rs2_haz || waw_haz);
    assign issue = i_id_valid && !i_flush && !haz && !i_mem_stall
                   && i_reg_write && rd_nonzero;

    // A memory freeze holds the front end but must not push a bubble: the
    // ID/EX register is frozen too, so the bubble would be lost or duplicated.
    assign o_stall_if    = haz | i_mem_stall;
    assign o_stall_id    = haz | i_mem_stall;
    assign o_flush_id_ex = haz & ~i_mem_stall;
    assign o_flush_if_id = 1'b0;

    // -------------------------------------------------------------------------
    // Per-register latency counters
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cnt
            if ((gi == 0) || (gi >= NUM_REGS)) begin : g_const
                assign cnt_view[gi] = LAT_ZERO;
            end else begin : g_reg
                logic [LAT_W-1:0] cnt_reg;
                logic [LAT_W-1:0] cnt_next;

                always_comb begin
                    cnt_next = cnt_reg;
                    if (!i_mem_stall) begin
                        if (cnt_reg != LAT_ZERO) begin
                            cnt_next = cnt_reg - LAT_ONE;
                        end
                        // A new issue replaces the decremented value.
                        if (issue && (i_rd == AW'(gi))) begin
                            cnt_next = i_lat;
                        end
                    end
                end

                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        cnt_reg <= LAT_ZERO;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end

                assign cnt_view[gi] = cnt_reg;
            end
        end

        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pending
            assign o_pending[gi] = (cnt_view[gi] != LAT_ZERO);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Hazard-stall performance counter (saturating). Memory freezes are not
    // attributed to hazards, so they do not count.
    // -------------------------------------------------------------------------
    always_comb begin
        stall_cycles_next = stall_cycles_reg;
        if (haz && !i_mem_stall && (stall_cycles_reg != {CNT_W{1'b1}})) begin
            stall_cycles_next = stall_cycles_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cycles_reg <= '0;
        end else begin
            stall_cycles_reg <= stall_cycles_next;
        end
    end

    assign o_stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Directed-vector bench for hazard_scoreboard. Two instances share the same
// stimulus: the default configuration and one with a 2-bit stall counter used
// to observe saturation. Inputs change 1 time unit after the rising edge and
// outputs are sampled 1 time unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam int NUM_REGS = 32;
    localparam int AW       = 5;
    localparam int LAT_W    = 3;
    localparam int CNT_W    = 32;

    logic                clk;
    logic                rst_n;
    logic                id_valid;
    logic [AW-1:0]       rs1;
    logic [AW-1:0]       rs2;
    logic                use_rs1;
    logic                use_rs2;
    logic                is_branch;
    logic                is_jump;
    logic [AW-1:0]       rd;
    logic                reg_write;
    logic [LAT_W-1:0]    lat;
    logic                mem_stall;
    logic                flush;

    logic                stall_if;
    logic                stall_id;
    logic                flush_id_ex;
    logic                flush_if_id;
    logic [NUM_REGS-1:0] pending;
    logic [CNT_W-1:0]    stall_cycles;

    logic                sat_stall_if;
    logic                sat_stall_id;
    logic                sat_flush_id_ex;
    logic                sat_flush_if_id;
    logic [NUM_REGS-1:0] sat_pending;
    logic [1:0]          sat_stall_cycles;

    int checks   = 0;
    int failures = 0;

    hazard_scoreboard #(
        .NUM_REGS(NUM_REGS), .AW(AW), .LAT_W(LAT_W), .CNT_W(CNT_W)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid),
        .i_rs1(rs1), .i_rs2(rs2), .i_use_rs1(use_rs1), .i_use_rs2(use_rs2),
        .i_is_branch(is_branch), .i_is_jump(is_jump), .i_rd(rd),
        .i_reg_write(reg_write), .i_lat(lat), .i_mem_stall(mem_stall),
        .i_flush(flush), .o_stall_if(stall_if), .o_stall_id(stall_id),
        .o_flush_id_ex(flush_id_ex), .o_flush_if_id(flush_if_id),
        .o_pending(pending), .o_stall_cycles(stall_cycles)
    );

    hazard_scoreboard #(
        .NUM_REGS(NUM_REGS), .AW(AW), .LAT_W(LAT_W), .CNT_W(2)
    ) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid),
        .i_rs1(rs1), .i_rs2(rs2), .i_use_rs1(use_rs1), .i_use_rs2(use_rs2),
        .i_is_branch(is_branch), .i_is_jump(is_jump), .i_rd(rd),
        .i_reg_write(reg_write), .i_lat(lat), .i_mem_stall(mem_stall),
        .i_flush(flush), .o_stall_if(sat_stall_if), .o_stall_id(sat_stall_id),
        .o_flush_id_ex(sat_flush_id_ex), .o_flush_if_id(sat_flush_if_id),
        .o_pending(sat_pending), .o_stall_cycles(sat_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs,
                            input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid  = 1'b0;
        rs1       = '0;
        rs2       = '0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        rd        = '0;
        reg_write = 1'b0;
        lat       = '0;
        mem_stall = 1'b0;
        flush     = 1'b0;
    endtask

    // Present a valid ID instruction and let the combinational outputs settle.
    task automatic set_instr(input int s1, input logic u1, input int s2,
                             input logic u2, input logic br, input int d,
                             input logic wr, input int l);
        id_valid  = 1'b1;
        rs1       = AW'(s1);
        use_rs1   = u1;
        rs2       = AW'(s2);
        use_rs2   = u2;
        is_branch = br;
        is_jump   = 1'b0;
        rd        = AW'(d);
        reg_write = wr;
        lat       = LAT_W'(l);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    // Count consecutive stall cycles of the instruction held in ID (bounded).
    task automatic count_stalls(output int n);
        n = 0;
        while (stall_id && (n < 20)) begin
            n++;
            tick();
        end
    endtask

    int n;

    initial begin
        idle();
        rst_n = 1'b0;
        #12;
        check_eq("reset_pending", pending, 0);
        check_eq("reset_stall_cycles", stall_cycles, 0);
        check_eq("reset_stall_id", stall_id, 0);
        check_eq("flush_if_id_const", flush_if_id, 0);
        mem_stall = 1'b1;
        #1;
        check_eq("reset_memstall_stall_if", stall_if, 1);
        mem_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---- load-use: load x5 lat 2, ALU consumer stalls one cycle ----
        set_instr(0, 0, 0, 0, 0, 5, 1, 2);
        check_eq("lu_producer_no_stall", stall_id, 0);
        tick();
        set_instr(5, 1, 0, 0, 0, 6, 1, 1);
        check_eq("lu_stall_id", stall_id, 1);
        check_eq("lu_flush_id_ex", flush_id_ex, 1);
        check_eq("lu_pending5", pending[5], 1);
        tick();
        check_eq("lu_released", stall_id, 0);
        check_eq("lu_stall_cycles", stall_cycles, 1);
        tick();
        idle();
        #1;
        check_eq("lu_pending_after", pending, 32'h0000_0040);

        // ---- ALU->branch (1), load->branch (2), ALU->ALU (0) ----
        do_reset();
        tick();
        set_instr(0, 0, 0, 0, 0, 3, 1, 1);
        tick();
        set_instr(3, 1, 0, 0, 1, 0, 0, 0);
        count_stalls(n);
        check_eq("alu_branch_stalls", n, 1);
        tick();
        set_instr(0, 0, 0, 0, 0, 4, 1, 2);
        tick();
        set_instr(0, 0, 4, 1, 1, 0, 0, 0);
        count_stalls(n);
        check_eq("load_branch_stalls", n, 2);
        tick();
        set_instr(0, 0, 0, 0, 0, 3, 1, 1);
        tick();
        set_instr(3, 1, 0, 0, 0, 11, 1, 1);
        count_stalls(n);
        check_eq("alu_alu_stalls", n, 0);
        tick();

        // ---- WAW: divide x7 lat 6, then ALU x7 lat 1 ----
        do_reset();
        tick();
        set_instr(0, 0, 0, 0, 0, 7, 1, 6);
        tick();
        set_instr(0, 0, 0, 0, 0, 7, 1, 1);
        n = 0;
        // cnt[7] goes 6,5,4,3,2 while exceeding the new latency of 1
        while (stall_id && (n < 20)) begin
            check_eq($sformatf("waw_pending7_c%0d", n), pending[7], 1);
            n++;
            tick();
        end
        check_eq("waw_stalls", n, 5);
        tick();
        idle();
        #1;
        check_eq("waw_issued_pending7", pending[7], 1);
        check_eq("waw_stall_cycles", stall_cycles, 5);

        // ---- memory freeze with a waiting load consumer ----
        do_reset();
        tick();
        set_instr(0, 0, 0, 0, 0, 2, 1, 2);
        tick();
        set_instr(2, 1, 0, 0, 0, 12, 1, 1);
        mem_stall = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            check_eq($sformatf("frz_stall_if_c%0d", c), stall_if, 1);
            check_eq($sformatf("frz_flush_id_ex_c%0d", c), flush_id_ex, 0);
            tick();
        end
        check_eq("frz_stall_cycles", stall_cycles, 0);
        check_eq("frz_pending2", pending[2], 1);
        mem_stall = 1'b0;
        #1;
        count_stalls(n);
        check_eq("frz_after_release_stalls", n, 1);
        tick();

        // ---- x0 writer and flushed hazardous consumer ----
        do_reset();
        tick();
        set_instr(0, 0, 0, 0, 0, 0, 1, 7);
        tick();
        idle();
        #1;
        check_eq("x0_pending", pending, 0);
        set_instr(0, 1, 0, 1, 1, 0, 0, 0);
        check_eq("x0_branch_stall", stall_id, 0);
        tick();
        set_instr(0, 0, 0, 0, 0, 8, 1, 2);
        tick();
        set_instr(8, 1, 0, 0, 0, 9, 1, 3);
        flush = 1'b1;
        #1;
        check_eq("flush_stall_id", stall_id, 0);
        check_eq("flush_flush_id_ex", flush_id_ex, 0);
        tick();
        idle();
        #1;
        check_eq("flush_no_issue_pending", pending, 32'h0000_0100);

        // ---- async reset mid-pending ----
        do_reset();
        tick();
        set_instr(0, 0, 0, 0, 0, 9, 1, 3);
        tick();
        idle();
        #1;
        check_eq("ar_pending9_before", pending[9], 1);
        rst_n = 1'b0;
        #1;
        check_eq("ar_pending_async", pending, 0);
        rst_n = 1'b1;
        tick();

        // ---- saturation: 5 hazard cycles into a 2-bit counter ----
        do_reset();
        tick();
        set_instr(0, 0, 0, 0, 0, 10, 1, 6);
        tick();
        set_instr(10, 1, 0, 0, 0, 13, 1, 1);
        count_stalls(n);
        check_eq("sat_stalls", n, 5);
        check_eq("sat_wide_counter", stall_cycles, 5);
        check_eq("sat_narrow_counter", sat_stall_cycles, 3);
        tick();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
